demux8v1_deser: RTL and testbench

- Sequential 1-to-8 demultiplexer and deserializer; the receive-side counterpart of the 8:1 mux path.
- An internal select counter routes each accepted serial bit into slot D[sel] of a shadow register.
- A complete word is transferred to a holding output register and offered downstream with a valid/ready handshake.
- Sits between a serial bit source (for example, an 8:1 mux driven by a counter) and parallel consumer logic.

---
 rtl/demux8v1_pkg.sv | 28 ++
 rtl/demux8v1_deser_slot_dec.sv | 26 ++
 rtl/demux8v1_deser.sv | 173 +++++++++++++++++
 tb/tb_demux8v1_deser.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux8v1_pkg.sv
// -----------------------------------------------------------------------------
// demux8v1_pkg
// Shared types, constants and helpers for the 1:8 demux / deserializer.
//   deser_state_t : FILL (collecting bits) / FULL (complete word waiting for
//                   the holding register to free up)
//   DEFAULT_WIDTH : default number of data bits per word
//   even_parity() : XOR of the low n bits of a 32-bit vector
// Optional build macro used by the top: DEMUX8V1_PARITY_EN
// -----------------------------------------------------------------------------
package demux8v1_pkg;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } deser_state_t;

   localparam int DEFAULT_WIDTH = 8;

   function automatic logic even_parity(input logic [31:0] bits, input int n);
      logic p;
      p = 1'b0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < unsigned'(n)) p = p ^ bits[i];
      end
      return p;
   endfunction

endpackage

// File: rtl/demux8v1_deser_slot_dec.sv
// -----------------------------------------------------------------------------
// demux8v1_slot_dec
// Combinational select-to-one-hot write-enable decoder (the demux proper).
// Ports:
//   sel [SEL_W-1:0] : slot index
//   en              : write request this cycle
//   we  [NSLOT-1:0] : one-hot write enable, all zero when en is low
// -----------------------------------------------------------------------------
module demux8v1_slot_dec #(
   parameter int NSLOT = 8,
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [NSLOT-1:0] we
);
   import demux8v1_pkg::*;

   always_comb begin
      we = '0;
      for (int unsigned i = 0; i < unsigned'(NSLOT); i++) begin
         if (en && (sel == SEL_W'(i))) we[i] = 1'b1;
      end
   end

endmodule

// File: rtl/demux8v1_deser.sv
// -----------------------------------------------------------------------------
// demux8v1_deser
// Sequential 1-to-WIDTH demultiplexer / deserializer. Accepted serial bits are
// written into slot sel of a shadow register; a complete word moves to the
// holding register out_data and is offered downstream with valid/ready.
// Ports:
//   clk, rst (async, active high), clr (sync flush of the partial word)
//   in_bit, in_valid, in_ready     : serial input handshake
//   out_data, out_valid, out_ready : parallel output handshake
//   sel                            : current slot index (observe only)
//   parity_err                     : only with DEMUX8V1_PARITY_EN
// Build option: `define DEMUX8V1_PARITY_EN adds a trailing even-parity bit per
// word (WIDTH+1 bits accepted) and the registered parity_err output.
// -----------------------------------------------------------------------------
module demux8v1_deser
   import demux8v1_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
`ifdef DEMUX8V1_PARITY_EN
   localparam int SEL_W = $clog2(WIDTH + 1)
`else
   localparam int SEL_W = $clog2(WIDTH)
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_bit,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SEL_W-1:0] sel
`ifdef DEMUX8V1_PARITY_EN
   ,
   output logic             parity_err
`endif
);

`ifdef DEMUX8V1_PARITY_EN
   localparam int LAST = WIDTH;
`else
   localparam int LAST = WIDTH - 1;
`endif
   localparam int NSLOT = LAST + 1;

   deser_state_t     state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [NSLOT-1:0] shadow_q, shadow_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
`ifdef DEMUX8V1_PARITY_EN
   logic             parity_err_q, parity_err_d;
   logic             word_err;
`endif

   logic [NSLOT-1:0] slot_we;
   logic [NSLOT-1:0] shadow_wr;
   logic             accept;
   logic             sel_last;
   logic             deq;
   logic             load;

   assign in_ready = (state_q == FILL);
   // clr drops a bit offered in the same cycle
   assign accept   = in_valid && in_ready && !clr;
   assign sel_last = (sel_q == SEL_W'(LAST));
   assign deq      = out_valid_q && out_ready;

   demux8v1_slot_dec #(
      .NSLOT (NSLOT),
      .SEL_W (SEL_W)
   ) u_slot_dec (
      .sel (sel_q),
      .en  (accept),
      .we  (slot_we)
   );

   // Shadow with this cycle's bit merged in. In FULL no bit is accepted, so
   // this equals the frozen shadow and serves as the load source for both the
   // direct completion and the FULL drain.
   assign shadow_wr = (shadow_q & ~slot_we) | (slot_we & {NSLOT{in_bit}});

`ifdef DEMUX8V1_PARITY_EN
   assign word_err = even_parity(32'(shadow_wr[WIDTH-1:0]), WIDTH) ^ shadow_wr[LAST];
`endif

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      shadow_d    = shadow_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      load        = 1'b0;
`ifdef DEMUX8V1_PARITY_EN
      parity_err_d = parity_err_q;
`endif

      // Dequeue clears valid unless a new word lands in the same cycle
      if (deq) out_valid_d = 1'b0;

      if (clr) begin
         state_d  = FILL;
         sel_d    = '0;
         shadow_d = '0;
      end else begin
         case (state_q)
            FILL: begin
               if (accept) begin
                  shadow_d = shadow_wr;
                  if (sel_last) begin
                     if (!out_valid_q || out_ready) begin
                        load  = 1'b1;
                        sel_d = '0;
                     end else begin
                        state_d = FULL;
                     end
                  end else begin
                     sel_d = sel_q + SEL_W'(1);
                  end
               end
            end
            FULL: begin
               if (out_ready) begin
                  load    = 1'b1;
                  sel_d   = '0;
                  state_d = FILL;
               end
            end
            default: state_d = FILL;
         endcase
      end

      if (load) begin
         out_data_d  = shadow_wr[WIDTH-1:0];
         out_valid_d = 1'b1;
`ifdef DEMUX8V1_PARITY_EN
         parity_err_d = word_err;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         sel_q       <= '0;
         shadow_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
`ifdef DEMUX8V1_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         shadow_q    <= shadow_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
`ifdef DEMUX8V1_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign sel       = sel_q;
`ifdef DEMUX8V1_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_demux8v1_deser.sv
// -----------------------------------------------------------------------------
// tb_demux8v1_deser
// Self-checking bench for demux8v1_deser: a queue-based model of accepted bits
// and the holding register is compared with the DUT on every falling edge,
// plus directed sequences with hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_demux8v1_deser;
   import demux8v1_pkg::*;

   localparam int WIDTH = 8;
`ifdef DEMUX8V1_PARITY_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif
   localparam int SEL_W = $clog2(NB);

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             clr = 1'b0;
   logic             in_bit = 1'b0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [SEL_W-1:0] sel;
`ifdef DEMUX8V1_PARITY_EN
   logic             parity_err;
`endif

   demux8v1_deser #(.WIDTH(WIDTH)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .in_bit     (in_bit),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sel        (sel)
`ifdef DEMUX8V1_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit               mq[$];      // bits of the word currently being collected
   logic             m_oval = 1'b0;
   logic [WIDTH-1:0] m_odata = '0;
   logic             m_perr = 1'b0;

   task automatic model_step();
      logic             old_oval;
      bit               held;
      bit               ld;
      logic [WIDTH-1:0] d;
      old_oval = m_oval;
      held     = (mq.size() == NB);
      ld       = 1'b0;
      if (m_oval && out_ready) m_oval = 1'b0;
      if (clr) begin
         mq.delete();
      end else if (held) begin
         if (out_ready) ld = 1'b1;
      end else if (in_valid) begin
         mq.push_back(in_bit);
         if (mq.size() == NB && (!old_oval || out_ready)) ld = 1'b1;
      end
      if (ld) begin
         d = '0;
         for (int k = 0; k < WIDTH; k++) d[k] = mq[k];
         m_odata = d;
         m_oval  = 1'b1;
`ifdef DEMUX8V1_PARITY_EN
         m_perr = even_parity(32'(d), WIDTH) ^ mq[NB-1];
`endif
         mq.delete();
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         mq.delete();
         m_oval  = 1'b0;
         m_odata = '0;
         m_perr  = 1'b0;
      end else begin
         model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      bit held;
      @(negedge clk);
      if (chk_en) begin
         held = (mq.size() == NB);
         check("in_ready", 32'(in_ready), 32'(!held));
         check("sel", 32'(sel), held ? 32'(NB - 1) : 32'(mq.size()));
         check("out_valid", 32'(out_valid), 32'(m_oval));
         check("out_data", 32'(out_data), 32'(m_odata));
`ifdef DEMUX8V1_PARITY_EN
         if (m_oval) check("parity_err", 32'(parity_err), 32'(m_perr));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input logic pbit);
      for (int i = 0; i < NB; i++) begin
         in_valid = 1'b1;
         in_bit   = (i < WIDTH) ? w[i] : pbit;
         tick();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int   cyc;
      int   pulses;
      int   t_first;
      int   t_second;
      logic [WIDTH-1:0] d_first;
      logic [WIDTH-1:0] d_second;
      bit   rdy_ok;
      logic [WIDTH-1:0] words [2];

      #1 rst = 1'b1;
      chk_en = 1'b1;
      #1;
      check("reset out_data", 32'(out_data), 32'h0);
      check("reset out_valid", 32'(out_valid), 32'h0);
      check("reset sel", 32'(sel), 32'h0);
      check("reset in_ready", 32'(in_ready), 32'h1);
      tick();
      tick();
      rst = 1'b0;

      // Word 0x4D, LSB first: 1,0,1,1,0,0,1,0
      out_ready = 1'b1;
      send_word(8'h4D, 1'b0);
      check("t1 out_valid", 32'(out_valid), 32'h1);
      check("t1 out_data", 32'(out_data), 32'h4D);
      check("t1 sel", 32'(sel), 32'h0);
      tick();
      check("t1 pulse end", 32'(out_valid), 32'h0);

      // Back-to-back words
      words[0] = 8'hA5;
      words[1] = 8'h3C;
      cyc = 0; pulses = 0; t_first = -1; t_second = -1;
      d_first = '0; d_second = '0; rdy_ok = 1'b1;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < NB; i++) begin
            in_valid = 1'b1;
            in_bit   = (i < WIDTH) ? words[w][i] : even_parity(32'(words[w]), WIDTH);
            rdy_ok   = rdy_ok & in_ready;
            tick();
            cyc++;
            if (out_valid) begin
               pulses++;
               if (pulses == 1) begin t_first = cyc; d_first = out_data; end
               else begin t_second = cyc; d_second = out_data; end
            end
         end
      end
      in_valid = 1'b0;
      check("t2 pulses", 32'(pulses), 32'd2);
      check("t2 spacing", 32'(t_second - t_first), 32'(NB));
      check("t2 word0", 32'(d_first), 32'hA5);
      check("t2 word1", 32'(d_second), 32'h3C);
      check("t2 in_ready held", 32'(rdy_ok), 32'h1);
      tick();

      // Pending 0x00, then 0x01 backs up into FULL
      out_ready = 1'b1;
      send_word(8'h00, 1'b0);
      out_ready = 1'b0;
      check("t3 pending valid", 32'(out_valid), 32'h1);
      send_word(8'h01, 1'b1);
      check("t3 full in_ready", 32'(in_ready), 32'h0);
      check("t3 full sel", 32'(sel), 32'(NB - 1));
      check("t3 full out_data", 32'(out_data), 32'h00);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t3 drain out_data", 32'(out_data), 32'h01);
      check("t3 drain out_valid", 32'(out_valid), 32'h1);
      check("t3 drain in_ready", 32'(in_ready), 32'h1);
      check("t3 drain sel", 32'(sel), 32'h0);
      out_ready = 1'b1;
      tick();
      check("t3 consumed", 32'(out_valid), 32'h0);

      // clr after 3 bits
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_bit = 1'b1; tick();
      end
      check("t4 sel before clr", 32'(sel), 32'd3);
      clr = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
      tick();
      clr = 1'b0; in_valid = 1'b0;
      check("t4 sel after clr", 32'(sel), 32'h0);
      send_word(8'h81, 1'b0);
      check("t4 out_data", 32'(out_data), 32'h81);
      check("t4 out_valid", 32'(out_valid), 32'h1);

      // Async reset mid-word, with a pending word in the holding register
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_bit = i[0]; tick();
      end
      in_valid = 1'b0;
      check("t5 sel mid-word", 32'(sel), 32'd5);
      check("t5 pending", 32'(out_valid), 32'h1);
      #1 rst = 1'b1;
      #1;
      check("t5 rst out_valid", 32'(out_valid), 32'h0);
      check("t5 rst sel", 32'(sel), 32'h0);
      check("t5 rst out_data", 32'(out_data), 32'h0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      send_word(8'h5A, even_parity(32'h5A, WIDTH));
      check("t5 clean word", 32'(out_data), 32'h5A);
      check("t5 clean valid", 32'(out_valid), 32'h1);
      tick();

`ifdef DEMUX8V1_PARITY_EN
      send_word(8'h4D, 1'b0);
      check("par ok data", 32'(out_data), 32'h4D);
      check("par ok err", 32'(parity_err), 32'h0);
      send_word(8'h4D, 1'b1);
      check("par bad data", 32'(out_data), 32'h4D);
      check("par bad err", 32'(parity_err), 32'h1);
      tick();
`endif

      // Randomized traffic with shifting back-pressure
      for (int n = 0; n < 3000; n++) begin
         int rdy_pct;
         rdy_pct   = ((n / 200) % 3 == 0) ? 90 : (((n / 200) % 3 == 1) ? 50 : 15);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_bit    = $urandom_range(0, 1) == 1;
         out_ready = ($urandom_range(0, 99) < rdy_pct);
         clr       = ($urandom_range(0, 39) == 0);
         tick();
      end
      clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
